pc_sequencer: RTL and testbench

Multi-cycle fetch/branch controller that owns the program counter and sequences the next-PC datapath. Each instruction passes through FETCH, DECODE and EXEC. The block then commits either the sequential PC or the ALU-computed target, using a 3-bit branch code evaluated against a signed condition operand. It sits between instruction memory (req/ack handshake) and the execute stage, and replaces ad-hoc PC update logic in the core.

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/br_cond.sv | 28 ++
 rtl/pc_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state, branch-code and reset constants for pc_sequencer
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } pc_state_e;

  localparam logic [2:0] BR_NEVER  = 3'd0;
  localparam logic [2:0] BR_ALWAYS = 3'd1;
  localparam logic [2:0] BR_LT     = 3'd2;
  localparam logic [2:0] BR_EQ     = 3'd3;
  localparam logic [2:0] BR_GT     = 3'd4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

  // Codes that take part in branch statistics; "never" codes are excluded.
  function automatic logic br_is_counted(input logic [2:0] code);
    return (code == BR_ALWAYS) || (code == BR_LT) || (code == BR_EQ) || (code == BR_GT);
  endfunction

endpackage

// File: rtl/br_cond.sv
// rtl/br_cond.sv - combinational branch-condition evaluator (signed compare against zero)
module br_cond
  import pc_seq_pkg::*;
(
  input  logic [2:0]  muxpc_i,
  input  logic [31:0] cond_a_i,
  output logic        taken_o
);

  logic is_neg;
  logic is_zero;

  assign is_neg  = cond_a_i[31];
  assign is_zero = (cond_a_i == 32'd0);

  // Decode the branch code; unused codes fall through to not-taken.
  always_comb begin
    taken_o = 1'b0;
    case (muxpc_i)
      BR_ALWAYS: taken_o = 1'b1;
      BR_LT:     taken_o = is_neg;
      BR_EQ:     taken_o = is_zero;
      BR_GT:     taken_o = !is_neg && !is_zero;
      default:   taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/decode/exec PC sequencer; optional BRANCH_STATS_EN adds branch counters
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic [2:0]  muxpc,
  input  logic [31:0] cond_a,
  input  logic [31:0] aluout,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] br_taken_cnt,
  output logic [31:0] br_nt_cnt
`endif
);

  // Counter only needs to reach WAIT_MAX-1; the next un-acked cycle faults.
  localparam int WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

  pc_state_e      state_q;
  logic [31:0]    pc_q;
  logic [31:0]    pc_d;
  logic [31:0]    instr_q;
  logic [WCW-1:0] wait_q;
  logic           req_q;
  logic           valid_q;
  logic           halted_q;
  logic           fault_q;
  logic           taken;

  br_cond u_br_cond (
    .muxpc_i  (muxpc),
    .cond_a_i (cond_a),
    .taken_o  (taken)
  );

  assign npc  = pc_q + PC_STEP;
  assign pc_d = taken ? aluout : npc;

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign state       = state_q;

  // Main sequencer: state, PC, instruction register, fetch timeout and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      wait_q   <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end
        ST_FETCH: begin
          // Ack has priority over the timeout on the same cycle.
          if (imem_ack) begin
            instr_q <= imem_rdata;
            wait_q  <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end else begin
            wait_q <= wait_q + WCW'(1);
          end
        end
        ST_DECODE: begin
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (ex_done) begin
            pc_q <= pc_d;
            if (halt_req) begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end else begin
              req_q   <= 1'b1;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          if (start) begin
            halted_q <= 1'b0;
            req_q    <= 1'b1;
            state_q  <= ST_FETCH;
          end
        end
        ST_FAULT: begin
          req_q   <= 1'b0;
          fault_q <= 1'b1;
        end
        default: begin
          req_q    <= 1'b0;
          halted_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] tk_cnt_q;
  logic [31:0] nt_cnt_q;

  assign br_taken_cnt = tk_cnt_q;
  assign br_nt_cnt    = nt_cnt_q;

  // Count resolved branches once per completed EXEC; never-codes are skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tk_cnt_q <= 32'd0;
      nt_cnt_q <= 32'd0;
    end else if ((state_q == ST_EXEC) && ex_done && br_is_counted(muxpc)) begin
      if (taken) begin
        tk_cnt_q <= tk_cnt_q + 32'd1;
      end else begin
        nt_cnt_q <= nt_cnt_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] STEP   = 32'd4;
  localparam int          WMAX   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        ex_done = 1'b0;
  logic [2:0]  muxpc = 3'd0;
  logic [31:0] cond_a = 32'd0;
  logic [31:0] aluout = 32'd0;
  logic        halt_req = 1'b0;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [2:0]  state;
  logic        halted;
  logic        fault;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_taken_cnt;
  logic [31:0] br_nt_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_tk;
  logic [31:0] m_nt;

  pc_sequencer #(
    .RESET_PC (RST_PC),
    .PC_STEP  (STEP),
    .WAIT_MAX (WMAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .ex_done     (ex_done),
    .muxpc       (muxpc),
    .cond_a      (cond_a),
    .aluout      (aluout),
    .halt_req    (halt_req),
    .pc          (pc),
    .npc         (npc),
    .state       (state),
    .halted      (halted),
    .fault       (fault)
`ifdef BRANCH_STATS_EN
    ,
    .br_taken_cnt (br_taken_cnt),
    .br_nt_cnt    (br_nt_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] c, input logic [31:0] a);
    int signed s;
    s = $signed(a);
    if (c == 3'd1) return 1'b1;
    if (c == 3'd2) return s < 0;
    if (c == 3'd3) return s == 0;
    if (c == 3'd4) return s > 0;
    return 1'b0;
  endfunction

  task automatic chk_reset(input string w);
    chk({w, ":pc"}, pc, RST_PC);
    chk({w, ":npc"}, npc, RST_PC + STEP);
    chk({w, ":state"}, {29'd0, state}, 32'd0);
    chk({w, ":imem_req"}, {31'd0, imem_req}, 32'd0);
    chk({w, ":imem_addr"}, imem_addr, RST_PC);
    chk({w, ":instr"}, instr, 32'd0);
    chk({w, ":instr_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({w, ":halted"}, {31'd0, halted}, 32'd0);
    chk({w, ":fault"}, {31'd0, fault}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk({w, ":br_taken_cnt"}, br_taken_cnt, 32'd0);
    chk({w, ":br_nt_cnt"}, br_nt_cnt, 32'd0);
`endif
  endtask

  // One instruction starting in FETCH: ack after ack_dly idle cycles, ex_done after ex_dly.
  task automatic do_instr(input logic [31:0] rdata, input int ack_dly, input logic [2:0] code,
                          input logic [31:0] ca, input logic [31:0] alu, input int ex_dly,
                          input logic hreq);
    for (int i = 0; i < ack_dly; i++) begin
      chk("fetch_state", {29'd0, state}, 32'd1);
      chk("fetch_req", {31'd0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, m_pc);
      start    = 1'($urandom_range(0, 1));
      halt_req = 1'($urandom_range(0, 1));
      ex_done  = 1'($urandom_range(0, 1));
      tick();
    end
    start      = 1'b0;
    halt_req   = 1'b0;
    ex_done    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("decode_state", {29'd0, state}, 32'd2);
    chk("decode_valid", {31'd0, instr_valid}, 32'd1);
    chk("decode_instr", instr, rdata);
    chk("decode_fault", {31'd0, fault}, 32'd0);
    tick();
    chk("exec_state", {29'd0, state}, 32'd3);
    chk("exec_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < ex_dly; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      tick();
      chk("exec_wait_pc", pc, m_pc);
    end
    imem_ack = 1'b0;
    ex_done  = 1'b1;
    muxpc    = code;
    cond_a   = ca;
    aluout   = alu;
    halt_req = hreq;
    tick();
    ex_done  = 1'b0;
    halt_req = 1'b0;
    if (code == 3'd1) m_tk = m_tk + 1;
    else if (code >= 3'd2 && code <= 3'd4) begin
      if (ref_taken(code, ca)) m_tk = m_tk + 1;
      else m_nt = m_nt + 1;
    end
    m_pc = ref_taken(code, ca) ? alu : m_pc + STEP;
    chk("commit_pc", pc, m_pc);
    chk("commit_npc", npc, m_pc + STEP);
    chk("commit_state", {29'd0, state}, hreq ? 32'd4 : 32'd1);
    chk("commit_halted", {31'd0, halted}, {31'd0, hreq});
    chk("commit_req", {31'd0, imem_req}, {31'd0, !hreq});
    if (!hreq) chk("commit_addr", imem_addr, m_pc);
`ifdef BRANCH_STATS_EN
    chk("br_taken_cnt", br_taken_cnt, m_tk);
    chk("br_nt_cnt", br_nt_cnt, m_nt);
`endif
  endtask

  // Sit in HALT with noise on ignored inputs, then restart.
  task automatic resume(input int idle);
    for (int i = 0; i < idle; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      ex_done  = 1'($urandom_range(0, 1));
      halt_req = 1'($urandom_range(0, 1));
      tick();
      chk("halt_state", {29'd0, state}, 32'd4);
      chk("halt_req_low", {31'd0, imem_req}, 32'd0);
      chk("halt_pc", pc, m_pc);
    end
    imem_ack = 1'b0;
    ex_done  = 1'b0;
    halt_req = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("resume_state", {29'd0, state}, 32'd1);
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_addr", imem_addr, m_pc);
  endtask

  initial begin
    logic [31:0] ca;
    logic [2:0]  code;
    logic        hq;

    m_pc = RST_PC;
    m_tk = 32'd0;
    m_nt = 32'd0;

    // Reset state
    tick();
    tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_hold", {29'd0, state}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", {29'd0, state}, 32'd1);
    chk("start_req", {31'd0, imem_req}, 32'd1);
    chk("start_addr", imem_addr, 32'h100);

    // Sequential, minimum loop
    do_instr(32'hDEAD_0001, 0, 3'd0, 32'd0, 32'h0000_0200, 0, 1'b0);
    chk("seq_pc_104", pc, 32'h104);

    // Directed branches
    do_instr(32'h1111_0002, 0, 3'd2, 32'hFFFF_FFFF, 32'h0000_0200, 1, 1'b0);
    chk("br_lt_taken", pc, 32'h200);
    do_instr(32'h1111_0003, 2, 3'd3, 32'h0000_0001, 32'h0000_0200, 0, 1'b0);
    chk("br_eq_nt", pc, 32'h204);
    do_instr(32'h1111_0004, 1, 3'd4, 32'h8000_0000, 32'h0000_0200, 2, 1'b0);
    chk("br_gt_nt", pc, 32'h208);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: ca = 32'd0;
        1: ca = 32'd1;
        2: ca = 32'hFFFF_FFFF;
        3: ca = 32'h8000_0000;
        4: ca = 32'h7FFF_FFFF;
        default: ca = $urandom;
      endcase
      code = 3'($urandom_range(0, 7));
      hq   = ($urandom_range(0, 7) == 0);
      do_instr($urandom, $urandom_range(0, 5), code, ca, $urandom & 32'hFFFF_FFFC,
               $urandom_range(0, 3), hq);
      if (hq) resume($urandom_range(0, 3));
    end

    // PC wrap with halt
    do_instr(32'h2222_0001, 0, 3'd1, 32'd0, 32'hFFFF_FFFC, 0, 1'b0);
    chk("wrap_pre_npc", npc, 32'd0);
    do_instr(32'h2222_0002, 0, 3'd0, 32'd0, 32'h0000_0200, 0, 1'b1);
    chk("wrap_pc_zero", pc, 32'd0);
    chk("wrap_halted", {31'd0, halted}, 32'd1);
    resume(2);
    chk("wrap_addr_zero", imem_addr, 32'd0);

    // Ack on the last allowed FETCH cycle wins over the timeout
    do_instr(32'h3333_0001, WMAX - 1, 3'd0, 32'd0, 32'd0, 0, 1'b0);

    // Timeout: no ack for WAIT_MAX cycles
    for (int i = 0; i < WMAX - 1; i++) begin
      tick();
      chk("to_still_fetch", {29'd0, state}, 32'd1);
      chk("to_no_fault", {31'd0, fault}, 32'd0);
    end
    tick();
    chk("to_state_fault", {29'd0, state}, 32'd5);
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_req_low", {31'd0, imem_req}, 32'd0);
    start    = 1'b1;
    imem_ack = 1'b1;
    tick();
    tick();
    start    = 1'b0;
    imem_ack = 1'b0;
    chk("fault_sticky_state", {29'd0, state}, 32'd5);
    chk("fault_sticky", {31'd0, fault}, 32'd1);

    // Reset clears fault
    rst_n = 1'b0;
    tick();
    m_pc = RST_PC;
    m_tk = 32'd0;
    m_nt = 32'd0;
    chk_reset("fault_reset");
    rst_n = 1'b1;

    // Reset asserted mid-EXEC while ex_done is high
    start = 1'b1;
    tick();
    start    = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("mid_exec_state", {29'd0, state}, 32'd3);
    ex_done = 1'b1;
    muxpc   = 3'd1;
    aluout  = 32'h0000_0550;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("exec_async_reset");
    tick();
    chk("exec_reset_pc_held", pc, RST_PC);
    ex_done = 1'b0;
    rst_n   = 1'b1;

    // Reset asserted mid-FETCH drops the request immediately
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_fetch_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("fetch_async_req", {31'd0, imem_req}, 32'd0);
    chk("fetch_async_state", {29'd0, state}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
